// File: rtl/pi_scheduler.sv
// Time-multiplexed PI controller: NCH channels share one multiply/accumulate datapath,
// granted round-robin and processed through a fixed IDLE/MULT/ACC/OUT sequence.
module pi_scheduler #(
    parameter int NCH  = 4,
    parameter int EW   = 16,
    parameter int OW   = 32,
    parameter int KP   = 32'sd1,
    parameter int KI   = 32'sd1000,
    parameter int IMAX = 32'sd1073741823
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*EW-1:0]      err,
    input  logic [NCH-1:0]         clr,
    output logic [NCH-1:0]         ack,
    output logic                   out_valid,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic [OW-1:0]          out_data,
    output logic                   busy
);

    localparam int CW = $clog2(NCH);
    localparam int PW = OW + EW;
    localparam int SW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic [NCH-1:0]        L_ONE    = {{(NCH-1){1'b0}}, 1'b1};
    localparam logic signed [OW-1:0]  L_IMAX   = OW'(IMAX);
    localparam logic signed [SW-1:0]  L_IMAX_X = SW'(L_IMAX);
    localparam logic signed [SW-1:0]  L_OMAX   = $signed({{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [SW-1:0]  L_OMIN   = $signed({{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}});

    // Sums are one bit wider than their operands, so these limits never see a wrapped value.
    function automatic logic signed [OW-1:0] clamp_integ(input logic signed [SW-1:0] v);
        if (v > L_IMAX_X) begin
            return L_IMAX;
        end else if (v < -L_IMAX_X) begin
            return -L_IMAX;
        end else begin
            return v[OW-1:0];
        end
    endfunction

    function automatic logic signed [OW-1:0] sat_out(input logic signed [SW-1:0] v);
        if (v > L_OMAX) begin
            return L_OMAX[OW-1:0];
        end else if (v < L_OMIN) begin
            return L_OMIN[OW-1:0];
        end else begin
            return v[OW-1:0];
        end
    endfunction

    logic [1:0]              r_state;
    logic [CW-1:0]           r_rr;
    logic [CW-1:0]           r_ch;
    logic signed [EW-1:0]    r_err;
    logic signed [PW-1:0]    r_p;
    logic signed [PW-1:0]    r_ip;
    logic signed [OW-1:0]    r_integ [NCH];
    logic [NCH-1:0]          r_ack;
    logic                    r_out_valid;
    logic [CW-1:0]           r_out_ch;
    logic signed [OW-1:0]    r_out_data;
    logic                    r_busy;

    logic                    w_gnt_vld;
    logic [CW-1:0]           w_gnt_ch;
    logic [CW-1:0]           w_idx;
    logic signed [PW-1:0]    w_err_x;
    logic signed [OW-1:0]    w_integ_cur;
    logic signed [OW-1:0]    w_integ_nxt;
    logic signed [SW-1:0]    w_acc_sum;
    logic signed [SW-1:0]    w_out_sum;

    // Round-robin arbiter: first requester at or above r_rr, wrapping modulo NCH.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = r_rr + CW'(i);
            if (!w_gnt_vld && req[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_idx;
            end else begin
                w_gnt_vld = w_gnt_vld;
            end
        end
    end

    // Shared datapath: sign-extended operands, integrator update and output sum.
    always_comb begin
        w_err_x     = PW'(r_err);
        w_integ_cur = r_integ[r_ch];
        w_acc_sum   = SW'(w_integ_cur) + SW'(r_ip);
        w_out_sum   = SW'(r_p) + SW'(w_integ_cur);
        w_integ_nxt = clamp_integ(w_acc_sum);
    end

    // Sequencer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr        <= '0;
            r_ch        <= '0;
            r_err       <= '0;
            r_p         <= '0;
            r_ip        <= '0;
            r_ack       <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_state <= ST_MULT;
                        r_busy  <= 1'b1;
                        r_ch    <= w_gnt_ch;
                        r_err   <= err[int'(w_gnt_ch)*EW +: EW];
                        r_ack   <= L_ONE << w_gnt_ch;
                    end
                end
                ST_MULT: begin
                    r_p     <= w_err_x * PW'(KP);
                    r_ip    <= w_err_x * PW'(KI);
                    r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    r_out_data  <= sat_out(w_out_sum);
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                    r_rr        <= r_ch + 1'b1;
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel integrators; a clear wins over the write-back of an in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_integ[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (clr[c]) begin
                    r_integ[c] <= '0;
                end else if (r_state == ST_ACC && r_ch == CW'(c)) begin
                    r_integ[c] <= w_integ_nxt;
                end
            end
        end
    end

    assign ack       = r_ack;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pi_scheduler.sv
// Directed bench for pi_scheduler: each scenario task drives its stimulus and checks inline.
module tb_pi_scheduler;

    localparam int NCH = 4;
    localparam int EW  = 16;
    localparam int OW  = 32;
    localparam int CW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [NCH*EW-1:0] err;
    logic [NCH-1:0]    clr;
    logic [NCH-1:0]    ack;
    logic              out_valid;
    logic [CW-1:0]     out_ch;
    logic [OW-1:0]     out_data;
    logic              busy;

    int n_pass;
    int n_total;

    pi_scheduler #(
        .NCH(NCH), .EW(EW), .OW(OW), .KP(1), .KI(1000), .IMAX(1073741823)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .err(err), .clr(clr), .ack(ack),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        req   = '0;
        clr   = '0;
        err   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One complete sample on an idle scheduler, checking ack and result timing.
    task automatic run_sample(input int ch, input logic signed [EW-1:0] e, output logic [OW-1:0] d);
        int cyc;
        logic [NCH-1:0] exp_ack;
        exp_ack = 4'b0001 << ch;
        err[ch*EW +: EW] = e;
        req[ch] = 1'b1;
        cyc = 0;
        while (ack[ch] !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_total++;
        if (cyc != 1) $display("FAIL ack_latency ch%0d: got %0d cycles, expected 1", ch, cyc);
        else n_pass++;
        n_total++;
        if (ack !== exp_ack || busy !== 1'b1)
            $display("FAIL ack_onehot ch%0d: ack=%b busy=%b, expected ack=%b busy=1", ch, ack, busy, exp_ack);
        else n_pass++;
        req[ch] = 1'b0;
        wait_valid(cyc);
        n_total++;
        if (cyc != 3 || out_ch !== CW'(ch))
            $display("FAIL out_timing ch%0d: latency=%0d out_ch=%0d, expected 3 and %0d", ch, cyc, out_ch, ch);
        else n_pass++;
        d = out_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req = '0; clr = '0; err = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (ack !== 4'b0000 || out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 32'd0 || busy !== 1'b0)
            $display("FAIL reset_state: ack=%b ov=%b ch=%0d data=%0d busy=%b, expected all 0",
                     ack, out_valid, out_ch, out_data, busy);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [OW-1:0] d;
        do_reset();
        run_sample(0, 16'sd5, d);
        n_total++;
        if ($signed(d) !== 5005) $display("FAIL single_first: got %0d, expected 5005", $signed(d));
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 32'd5005 || busy !== 1'b0)
            $display("FAIL single_hold: ov=%b data=%0d busy=%b, expected 0/5005/0", out_valid, out_data, busy);
        else n_pass++;
        run_sample(0, 16'sd5, d);
        n_total++;
        if ($signed(d) !== 10005) $display("FAIL single_second: got %0d, expected 10005", $signed(d));
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [OW-1:0] d;
        logic [NCH-1:0] exp_ack;
        int cyc, last, got;
        do_reset();
        req = 4'b1111;
        cyc = 0; last = 0; got = 0;
        while (got < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack !== 4'b0000) begin
                exp_ack = 4'b0001 << got;
                n_total++;
                if (ack !== exp_ack) $display("FAIL rr_order: grant %0d ack=%b, expected %b", got, ack, exp_ack);
                else n_pass++;
                if (got > 0) begin
                    n_total++;
                    if (cyc - last != 4) $display("FAIL rr_spacing: %0d cycles between grants, expected 4", cyc - last);
                    else n_pass++;
                end
                last = cyc;
                req = req & ~ack;
                got++;
            end
        end
        n_total++;
        if (got != 4) $display("FAIL rr_timeout: %0d grants seen, expected 4", got);
        else n_pass++;
        wait_valid(cyc);
        run_sample(1, 16'sd0, d);
        req = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            exp_ack = (k == 0) ? 4'b1000 : 4'b0010;
            cyc = 0;
            while (ack === 4'b0000 && cyc < 12) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            n_total++;
            if (ack !== exp_ack) $display("FAIL rr_wrap: grant %0d ack=%b, expected %b", k, ack, exp_ack);
            else n_pass++;
            req = req & ~exp_ack;
            wait_valid(cyc);
        end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] d;
        longint acc;
        int exp_d;
        do_reset();
        acc = 0;
        for (int s = 1; s <= 34; s++) begin
            run_sample(0, 16'sd32767, d);
            acc = acc + 64'sd32767000;
            if (acc > 64'sd1073741823) acc = 64'sd1073741823;
            exp_d = int'(acc + 64'sd32767);
            n_total++;
            if ($signed(d) !== exp_d) $display("FAIL sat_pos sample %0d: got %0d, expected %0d", s, $signed(d), exp_d);
            else n_pass++;
        end
        clr[0] = 1'b1;
        @(posedge clk);
        #1 clr[0] = 1'b0;
        acc = 0;
        for (int s = 1; s <= 34; s++) begin
            run_sample(0, -16'sd32768, d);
            acc = acc - 64'sd32768000;
            if (acc < -64'sd1073741823) acc = -64'sd1073741823;
            exp_d = int'(acc - 64'sd32768);
            n_total++;
            if ($signed(d) !== exp_d) $display("FAIL sat_neg sample %0d: got %0d, expected %0d", s, $signed(d), exp_d);
            else n_pass++;
        end
        run_sample(1, 16'sd0, d);
        n_total++;
        if ($signed(d) !== 0) $display("FAIL sat_isolation: ch1 got %0d, expected 0", $signed(d));
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [OW-1:0] d;
        int cyc;
        do_reset();
        for (int s = 1; s <= 3; s++) begin
            run_sample(1, 16'sd1, d);
            n_total++;
            if ($signed(d) !== s * 1000 + 1) $display("FAIL clr_build: got %0d, expected %0d", $signed(d), s * 1000 + 1);
            else n_pass++;
        end
        err[EW +: EW] = 16'sd1;
        req[1] = 1'b1;
        cyc = 0;
        while (ack[1] !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        req[1] = 1'b0;
        @(posedge clk);
        #1 clr[1] = 1'b1;
        @(posedge clk);
        #1 clr[1] = 1'b0;
        wait_valid(cyc);
        n_total++;
        if (cyc != 1 || $signed(out_data) !== 1)
            $display("FAIL clr_inflight: latency=%0d data=%0d, expected 1 and 1", cyc, $signed(out_data));
        else n_pass++;
        run_sample(1, 16'sd1, d);
        n_total++;
        if ($signed(d) !== 1001) $display("FAIL clr_after: got %0d, expected 1001", $signed(d));
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [OW-1:0] d;
        int cyc;
        logic seen;
        do_reset();
        run_sample(1, 16'sd1, d);
        err[EW +: EW] = 16'sd3;
        req[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL midop_busy: busy=%b, expected 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        req = '0;
        #1;
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ack !== 4'b0000)
            $display("FAIL midop_reset: busy=%b ov=%b ack=%b, expected 0/0/0000", busy, out_valid, ack);
        else n_pass++;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL midop_no_valid: out_valid=%b during reset, expected 0", seen);
        else n_pass++;
        rst_n = 1'b1;
        err = '0;
        req = 4'b0110;
        cyc = 0;
        while (ack === 4'b0000 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_total++;
        if (ack !== 4'b0010) $display("FAIL midop_rr: ack=%b, expected 0010", ack);
        else n_pass++;
        req = '0;
        wait_valid(cyc);
        n_total++;
        if (out_ch !== 2'd1 || out_data !== 32'd0)
            $display("FAIL midop_integ: ch=%0d data=%0d, expected 1 and 0", out_ch, $signed(out_data));
        else n_pass++;
        run_sample(2, 16'sd5, d);
        n_total++;
        if ($signed(d) !== 5005 || out_ch !== 2'd2)
            $display("FAIL midop_ch2: ch=%0d data=%0d, expected 2 and 5005", out_ch, $signed(d));
        else n_pass++;
    endtask

    task automatic test_negative();
        logic [OW-1:0] d;
        do_reset();
        run_sample(0, 16'sd7, d);
        run_sample(1, 16'sd1, d);
        run_sample(3, 16'sd2, d);
        run_sample(2, -16'sd4, d);
        n_total++;
        if ($signed(d) !== -4004) $display("FAIL neg_ch2: got %0d, expected -4004", $signed(d));
        else n_pass++;
        run_sample(0, 16'sd0, d);
        n_total++;
        if ($signed(d) !== 7000) $display("FAIL neg_ch0: got %0d, expected 7000", $signed(d));
        else n_pass++;
        run_sample(1, 16'sd0, d);
        n_total++;
        if ($signed(d) !== 1000) $display("FAIL neg_ch1: got %0d, expected 1000", $signed(d));
        else n_pass++;
        run_sample(3, 16'sd0, d);
        n_total++;
        if ($signed(d) !== 2000) $display("FAIL neg_ch3: got %0d, expected 2000", $signed(d));
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_clear();
        test_reset_midop();
        test_negative();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pi_scheduler.md
PI_SCHEDULER -- requirements
Module: pi_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4: number of PI channels sharing one datapath; power of two, 2..8.
REQ-002 SHALL have parameter EW, default 16: signed error width per channel.
REQ-003 SHALL have parameter OW, default 32: signed output and integrator width.
REQ-004 SHALL have parameter KP, default 1: signed proportional gain.
REQ-005 SHALL have parameter KI, default 1000: signed integral gain.
REQ-006 SHALL have parameter IMAX, default 2^30-1: integrator clamp magnitude, limits +IMAX and -IMAX.
REQ-007 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port req  input  NCH  per-channel sample request; level, held until ack.
REQ-010 SHALL have port err  input  NCH*EW  packed signed errors; channel c occupies bits [c*EW +: EW] and is stable while req[c] is high.
REQ-011 SHALL have port clr  input  NCH  per-channel integrator clear, level-sensitive.
REQ-012 SHALL have port ack  output  NCH  one-hot one-cycle pulse marking the accepted sample.
REQ-013 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-014 SHALL have port out_ch  output  log2(NCH)  channel index of the result.
REQ-015 SHALL have port out_data  output  OW  signed PI result.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> MULT -> ACC -> OUT -> IDLE; MULT, ACC and OUT each last exactly one cycle.
REQ-018 SHALL, in IDLE with any req bit high, grant the first requesting channel searching upward from pointer rr, with wrap-around.
- The grant SHALL latch err and the channel index, and SHALL move the FSM to MULT.
REQ-019 SHALL assert ack[ch] for exactly the MULT cycle; all other ack bits SHALL be 0.
REQ-020 SHALL, in MULT, register p = err*KP and ip = err*KI, each sign-extended to OW+EW bits.
REQ-021 SHALL, in ACC, write integ[ch] = clamp(integ[ch] + ip, -IMAX, +IMAX).
- The clamp SHALL be computed at full width with no wrap-around.
REQ-022 SHALL, in OUT, drive out_data = saturate(p + integ[ch]) to the signed OW range, with out_ch = ch and out_valid = 1.
- rr SHALL become (ch+1) mod NCH.
REQ-023 SHALL produce out_valid exactly 3 cycles after the grant edge; peak throughput is one sample per 4 cycles.
REQ-024 SHALL hold out_data and out_ch between strobes; out_valid SHALL be 0 outside OUT.
REQ-025 SHALL ignore req while busy; no request is lost, because requesters hold req until ack.
REQ-026 SHALL zero integ[c] on any cycle where clr[c] = 1.
- clr SHALL override a simultaneous ACC write-back to the same channel.
- An in-flight result SHALL still be emitted; its integral term is the value read in OUT.
REQ-027 SHALL keep per-channel integrators independent; a clamp on one channel SHALL NOT affect the others.

Reset
REQ-028 SHALL, while rst_n = 0, force state IDLE, rr = 0, all integ = 0, ack = 0, out_valid = 0, out_ch = 0, out_data = 0 and busy = 0.
REQ-029 SHALL, on reset asserted mid-operation, abandon the in-flight sample without producing out_valid; the first grant after release SHALL start from channel 0.

Verification
REQ-030 Single sample: reset, req[0] = 1 with err0 = 5 -> ack[0] 1 cycle after grant, out_valid 3 cycles after grant, out_ch = 0, out_data = 5005; repeating err0 = 5 -> out_data = 10005.
REQ-031 Round-robin: req = 1111 held, each released after its ack -> grants 0,1,2,3 in that order, one every 4 cycles; with req = 1010 and rr = 2 -> grant order 3,1.
REQ-032 Saturation: err0 = 32767 repeated -> integ[0] grows by 32767000 per sample and clamps at 1073741823 on the 33rd sample, holding there; err0 = -32768 repeated -> clamps at -1073741823.
REQ-033 Clear: integ[1] = 3000, clr[1] pulsed during ACC of channel 1 -> integ[1] = 0 afterwards, and the next err1 = 1 yields out_data = 1001.
REQ-034 Reset mid-op: rst_n low during ACC -> no out_valid, busy = 0, all integrators 0; after release, req = 0100 -> out_ch = 2.
REQ-035 Negative error: err2 = -4 -> out_data = -4004; channels 0, 1 and 3 are unchanged.
